fetch_stage: RTL and testbench

//  Instruction-fetch front end of the pipelined core; feeds the decode stage of the pipeline.
//  - Owns the PC and issues sequential requests to instruction memory.
//  - Buffers returned words in a small FIFO.
//  - Presents them to decode with a valid/ready handshake.
//  - Redirects from EX (branch/jump) reload the PC and flush everything in flight.

---
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: EX redirect, instruction-memory request/response and
// the valid/ready handshake toward decode. "master" is the fetch stage side.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

interface fetch_stage_if #(
    parameter int AddrSize = `ADDR_SIZE,
    parameter int DataSize = 32
);
    logic                redirect_i;
    logic [AddrSize-1:0] redirect_pc_i;
    logic                imem_req_o;
    logic [AddrSize-1:0] imem_addr_o;
    logic                imem_gnt_i;
    logic                imem_rvalid_i;
    logic [DataSize-1:0] imem_rdata_i;
    logic                id_valid_o;
    logic                id_ready_i;
    logic [DataSize-1:0] id_instr_o;
    logic [AddrSize-1:0] id_pc_o;

    modport master (
        input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, id_ready_i,
        input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues sequential fetches, buffers
// returned words in a small circular FIFO and hands them to decode.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module fetch_stage #(
    parameter int                  AddrSize = `ADDR_SIZE,
    parameter int                  DataSize = 32,
    parameter logic [AddrSize-1:0] ResetPc  = '0,
    parameter int                  Depth    = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_stage_if.master bus
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth) + 1;
    localparam int OccW = CntW + 1;

    logic [AddrSize-1:0] pc_q, pc_d;
    logic [AddrSize-1:0] pend_pc_q, pend_pc_d;
    logic                pending_q, pending_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [DataSize-1:0] instr_mem_q [Depth];
    logic [DataSize-1:0] instr_mem_d [Depth];
    logic [AddrSize-1:0] pc_mem_q [Depth];
    logic [AddrSize-1:0] pc_mem_d [Depth];

    logic                pop, push, req, grant;
    logic [OccW-1:0]     credit_used;

    // A word popped this cycle frees its slot in time for a new request.
    always_comb begin
        pop         = (count_q != '0) && bus.id_ready_i && !rst_i;
        credit_used = OccW'(count_q) + OccW'(pending_q) - OccW'(pop);
        req         = !rst_i && !bus.redirect_i && (credit_used < OccW'(Depth));
        grant       = req && bus.imem_gnt_i;
        push        = bus.imem_rvalid_i && pending_q && !bus.redirect_i;
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_q;
    assign bus.id_valid_o  = !rst_i && (count_q != '0);
    assign bus.id_instr_o  = rst_i ? '0 : instr_mem_q[rd_ptr_q];
    assign bus.id_pc_o     = rst_i ? '0 : pc_mem_q[rd_ptr_q];

    always_comb begin
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        pending_d = grant;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        if (bus.redirect_i) begin
            // Redirect flushes the FIFO and drops the in-flight response.
            pc_d      = {bus.redirect_pc_i[AddrSize-1:2], 2'b00};
            pending_d = 1'b0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            if (grant) begin
                pc_d      = pc_q + AddrSize'(4);
                pend_pc_d = pc_q;
            end
            if (push) begin
                instr_mem_d[wr_ptr_q] = bus.imem_rdata_i;
                pc_mem_d[wr_ptr_q]    = pend_pc_q;
                wr_ptr_d              = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q      <= ResetPc;
            pend_pc_q <= '0;
            pending_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < Depth; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            pending_q   <= pending_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: hand-derived vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_fetch_stage;
    localparam int          AW     = 32;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if #(.AddrSize(AW), .DataSize(DW)) bus ();

    fetch_stage #(.AddrSize(AW), .DataSize(DW), .ResetPc(RST_PC), .Depth(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    // Reference model: words owned by the stage, in delivery order.
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;

    // Memory environment: answers each grant exactly one cycle later.
    bit          rv_next;
    logic [31:0] rd_next;

    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_instr;

    typedef struct {
        bit          rst;
        bit          rd;
        logic [31:0] rpc;
        bit          g;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    endtask

    task automatic step(input bit r, input bit rd, input logic [31:0] rpc,
                        input bit g, input bit rdy, input bit spur);
        bit exp_valid, pop, exp_req;
        int occ;
        @(negedge clk);
        rst               = r;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.imem_gnt_i    = g;
        bus.id_ready_i    = rdy;
        bus.imem_rvalid_i = rv_next;
        bus.imem_rdata_i  = rv_next ? rd_next : $urandom;
        if (spur && !rv_next) begin
            bus.imem_rvalid_i = 1'b1;
            bus.imem_rdata_i  = $urandom;
        end
        #1;
        o_req   = bus.imem_req_o;
        o_addr  = bus.imem_addr_o;
        o_valid = bus.id_valid_o;
        o_pc    = bus.id_pc_o;
        o_instr = bus.id_instr_o;
        rv_next = o_req && g;
        rd_next = mem_word(o_addr);

        if (r) begin
            check("rst_req", {31'b0, o_req}, 32'd0);
            check("rst_valid", {31'b0, o_valid}, 32'd0);
            check("rst_pc", o_pc, 32'd0);
            check("rst_instr", o_instr, 32'd0);
            mq.delete();
            m_pend = 1'b0;
            m_pc   = RST_PC;
        end else begin
            exp_valid = (mq.size() != 0);
            check("id_valid", {31'b0, o_valid}, {31'b0, exp_valid});
            if (exp_valid) begin
                check("id_pc", o_pc, mq[0].pc);
                check("id_instr", o_instr, mq[0].instr);
            end
            pop     = exp_valid && rdy;
            occ     = mq.size() + int'(m_pend) - int'(pop);
            exp_req = !rd && (occ < DEPTH);
            check("imem_req", {31'b0, o_req}, {31'b0, exp_req});
            if (exp_req) check("imem_addr", o_addr, m_pc);
            if (rd) begin
                mq.delete();
                m_pend = 1'b0;
                m_pc   = rpc & 32'hFFFF_FFFC;
            end else begin
                if (pop) void'(mq.pop_front());
                if (bus.imem_rvalid_i && m_pend) mq.push_back('{m_pend_pc, mem_word(m_pend_pc)});
                if (exp_req && g) begin
                    m_pend    = 1'b1;
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end else begin
                    m_pend = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = '0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.id_ready_i    = 1'b0;
        rv_next = 1'b0;
        rd_next = '0;
        m_pend  = 1'b0;
        m_pc    = RST_PC;
        m_pend_pc = '0;

        //            rst rd  rpc          g  rdy req addr          valid pc
        tbl[0]  = '{1, 0, 32'h0,      1, 1, 0, 32'h0000_0100, 0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_0100, 0, 32'h0};
        tbl[2]  = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_0104, 0, 32'h0};
        tbl[3]  = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_0108, 1, 32'h0000_0100};
        tbl[4]  = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_010C, 1, 32'h0000_0104};
        tbl[5]  = '{0, 0, 32'h0,      1, 0, 0, 32'h0000_0110, 1, 32'h0000_0108};
        tbl[6]  = '{0, 0, 32'h0,      1, 0, 0, 32'h0000_0110, 1, 32'h0000_0108};
        tbl[7]  = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_0110, 1, 32'h0000_0108};
        tbl[8]  = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_0114, 1, 32'h0000_010C};
        tbl[9]  = '{0, 1, 32'h2002,   1, 1, 0, 32'h0000_0118, 1, 32'h0000_0110};
        tbl[10] = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_2000, 0, 32'h0};
        tbl[11] = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_2004, 0, 32'h0};
        tbl[12] = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_2008, 1, 32'h0000_2000};
        tbl[13] = '{0, 0, 32'h0,      0, 1, 1, 32'h0000_200C, 1, 32'h0000_2004};
        tbl[14] = '{0, 0, 32'h0,      0, 1, 1, 32'h0000_200C, 1, 32'h0000_2008};
        tbl[15] = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_200C, 0, 32'h0};
        tbl[16] = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_2010, 0, 32'h0};
        tbl[17] = '{0, 0, 32'h0,      1, 1, 1, 32'h0000_2014, 1, 32'h0000_200C};

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].rst, tbl[i].rd, tbl[i].rpc, tbl[i].g, tbl[i].rdy, 1'b0);
            check($sformatf("tbl%0d_req", i), {31'b0, o_req}, {31'b0, tbl[i].e_req});
            check($sformatf("tbl%0d_addr", i), o_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_valid", i), {31'b0, o_valid}, {31'b0, tbl[i].e_valid});
            if (tbl[i].rst || tbl[i].e_valid)
                check($sformatf("tbl%0d_pc", i), o_pc, tbl[i].e_pc);
            if (tbl[i].e_valid)
                check($sformatf("tbl%0d_instr", i), o_instr, mem_word(tbl[i].e_pc));
        end

        // PC wrap-around.
        step(0, 1, 32'hFFFF_FFFC, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0); check("wrap_a0", o_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 1, 0); check("wrap_a1", o_addr, 32'h0000_0000);
        step(0, 0, 0, 1, 1, 0); check("wrap_a2", o_addr, 32'h0000_0004);
                                check("wrap_p0", o_pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 1, 0); check("wrap_p1", o_pc, 32'h0000_0000);
        step(0, 0, 0, 1, 1, 0); check("wrap_p2", o_pc, 32'h0000_0004);

        // Decode stall: FIFO fills, requests stop, then redirect with stray rvalid.
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0);
        check("stall_req", {31'b0, o_req}, 32'd0);
        check("stall_valid", {31'b0, o_valid}, 32'd1);
        step(0, 1, 32'h0000_2002, 1, 0, 1);
        step(0, 0, 0, 1, 1, 0);
        check("redir_empty", {31'b0, o_valid}, 32'd0);
        check("redir_addr", o_addr, 32'h0000_2000);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        check("redir_pc", o_pc, 32'h0000_2000);

        // Stall then release: PCs continue without a gap.
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 1, 0);

        // Reset with a grant outstanding; the late and a spurious rvalid are ignored.
        step(0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 1);
        check("rst6_valid0", {31'b0, o_valid}, 32'd0);
        check("rst6_addr", o_addr, RST_PC);
        step(0, 0, 0, 1, 1, 0);
        check("rst6_valid1", {31'b0, o_valid}, 32'd0);
        step(0, 0, 0, 1, 1, 0);
        check("rst6_valid2", {31'b0, o_valid}, 32'd1);
        check("rst6_pc", o_pc, RST_PC);

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit          r, rd, g, rdy, spur;
            logic [31:0] rpc;
            r    = ($urandom_range(0, 199) == 0);
            rd   = ($urandom_range(0, 19) == 0);
            rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
            g    = ($urandom_range(0, 9) < 7);
            rdy  = ($urandom_range(0, 9) < 7);
            spur = ($urandom_range(0, 9) == 0);
            step(r, rd, rpc, g, rdy, spur);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
